// File: rtl/score_to_segments_pkg.sv
// Shared constants for the score display path: active-low {g..a} digit patterns,
// the conversion state enum and the default saturation ceiling.
package score_to_segments_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int SAT_VALUE_DEFAULT = 9999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ENCODE
  } state_t;

  // Non-decimal nibbles cannot occur after saturation; they show as dark.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/score_to_segments_seg7_encode.sv
// Combinational BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_encode
  import score_to_segments_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = digit_to_seg(digit);

endmodule

// File: rtl/score_to_segments.sv
// Sequential double-dabble score encoder driving four held 7-segment patterns.
// Optional LEADING_ZERO_BLANK_EN blanks leading zeros on num3..num1.
module score_to_segments
  import score_to_segments_pkg::*;
#(
  parameter int VALUE_W   = 14,
  parameter int SAT_VALUE = SAT_VALUE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [VALUE_W-1:0] value,
  output logic               busy,
  output logic               done,
  output logic [6:0]         num0,
  output logic [6:0]         num1,
  output logic [6:0]         num2,
  output logic [6:0]         num3
);

  localparam int                 CNT_W      = $clog2(VALUE_W + 1);
  localparam int                 DD_W       = 16 + VALUE_W;
  localparam logic [VALUE_W-1:0] SAT_LIMIT  = VALUE_W'(SAT_VALUE);
  localparam logic [CNT_W-1:0]   LAST_SHIFT = CNT_W'(VALUE_W - 1);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] SEG_UPPER_RST = SEG_BLANK;
`else
  localparam logic [6:0] SEG_UPPER_RST = SEG_0;
`endif

  state_t             state_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [VALUE_W-1:0] bin_reg;
  logic [15:0]        bcd_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [6:0]         num_reg  [4];
  logic [6:0]         num_next [4];
  logic [6:0]         seg_pat  [4];
  logic [15:0]        bcd_adj;
  logic [DD_W-1:0]    dd_shifted;
  logic [VALUE_W-1:0] value_sat;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
      seg7_encode u_seg7_encode (
        .digit (bcd_reg[gi*4 +: 4]),
        .seg   (seg_pat[gi])
      );
    end
  endgenerate

  assign dd_shifted = {bcd_adj, bin_reg} << 1;
  assign value_sat  = (value > SAT_LIMIT) ? SAT_LIMIT : value;

  // Blanking cascades from the thousands digit down; num0 always shows.
  always_comb begin
    for (int i = 0; i < 4; i++) num_next[i] = seg_pat[i];
`ifdef LEADING_ZERO_BLANK_EN
    if (bcd_reg[15:12] == 4'd0) begin
      num_next[3] = SEG_BLANK;
      if (bcd_reg[11:8] == 4'd0) begin
        num_next[2] = SEG_BLANK;
        if (bcd_reg[7:4] == 4'd0) num_next[1] = SEG_BLANK;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      bin_reg    <= '0;
      bcd_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      num_reg[0] <= SEG_0;
      for (int i = 1; i < 4; i++) num_reg[i] <= SEG_UPPER_RST;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            bin_reg   <= value_sat;
            bcd_reg   <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_reg, bin_reg} <= dd_shifted;
          count_reg          <= count_reg + CNT_W'(1);
          if (count_reg == LAST_SHIFT) state_reg <= ENCODE;
        end
        ENCODE: begin
          for (int i = 0; i < 4; i++) num_reg[i] <= num_next[i];
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign num0 = num_reg[0];
  assign num1 = num_reg[1];
  assign num2 = num_reg[2];
  assign num3 = num_reg[3];

endmodule

// File: tb/tb_score_to_segments.sv
// Self-checking bench for score_to_segments: constant vector table, hand-written
// corner sequences and random values against an arithmetic decimal model.
module tb_score_to_segments;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0010000;
  localparam logic [6:0] PB = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] UZ = PB;
`else
  localparam logic [6:0] UZ = P0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] value;
  logic        busy;
  logic        done;
  logic [6:0]  num0, num1, num2, num3;

  int checks = 0;
  int passes = 0;

  score_to_segments dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .num0  (num0),
    .num1  (num1),
    .num2  (num2),
    .num3  (num3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] v;
    logic [27:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return P0;  1: return P1;  2: return P2;  3: return P3;  4: return P4;
      5: return P5;  6: return P6;  7: return P7;  8: return P8;  default: return P9;
    endcase
  endfunction

  // Decimal digits by division; leading blanks from the count of significant digits.
  function automatic logic [27:0] model(input int v);
    int sv, s, ndig;
    logic [6:0] p [4];
    sv = (v > 9999) ? 9999 : v;
    s  = sv;
    for (int i = 0; i < 4; i++) begin
      p[i] = pat(s % 10);
      s    = s / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    ndig = (sv >= 1000) ? 4 : (sv >= 100) ? 3 : (sv >= 10) ? 2 : 1;
    for (int i = 1; i < 4; i++) if (i >= ndig) p[i] = PB;
`else
    ndig = 4;
`endif
    return {p[3], p[2], p[1], p[0]};
  endfunction

  function automatic logic [27:0] outs();
    return {num3, num2, num1, num0};
  endfunction

  task automatic conv(input logic [13:0] v, input string nm, output logic [27:0] res);
    logic [27:0] snap;
    bit          stable;
    int          lat;
    snap   = outs();
    stable = 1'b1;
    lat    = 0;
    @(negedge clk); start = 1'b1; value = v;
    @(posedge clk); #1;
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    @(negedge clk); start = 1'b0; value = 14'($urandom);
    while (lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (!busy || outs() != snap) stable = 1'b0;
    end
    chk({nm, "_lat"}, 32'(lat), 32'd15);
    chk({nm, "_hold"}, 32'(stable), 32'd1);
    res = outs();
    $display("conv %s value=%0d result=%07b_%07b_%07b_%07b latency=%0d",
             nm, v, res[27:21], res[20:14], res[13:7], res[6:0], lat);
    @(posedge clk); #1;
    chk({nm, "_pulse"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    vec_t        tbl [10];
    logic [27:0] res, r0, r1;
    bit          ok;
    int          lat, t, first, second;
    logic [13:0] rv;

    tbl[0] = '{14'd1234,  {P1, P2, P3, P4}};
    tbl[1] = '{14'd12000, {P9, P9, P9, P9}};
    tbl[2] = '{14'd0,     {UZ, UZ, UZ, P0}};
    tbl[3] = '{14'd7,     {UZ, UZ, UZ, P7}};
    tbl[4] = '{14'd9999,  {P9, P9, P9, P9}};
    tbl[5] = '{14'd10000, {P9, P9, P9, P9}};
    tbl[6] = '{14'd16383, {P9, P9, P9, P9}};
    tbl[7] = '{14'd1005,  {P1, P0, P0, P5}};
    tbl[8] = '{14'd80,    {UZ, UZ, P8, P0}};
    tbl[9] = '{14'd506,   {UZ, P5, P0, P6}};

    rst = 1'b1; start = 1'b0; value = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    ok = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (busy || done || outs() != {UZ, UZ, UZ, P0}) ok = 1'b0;
    end
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_num0", 32'(num0), 32'(P0));
    chk("rst_upper", {11'd0, num3, num2, num1}, {11'd0, UZ, UZ, UZ});
    chk("idle_quiet", 32'(ok), 32'd1);
    $display("reset idle checked ok=%0d", ok);

    for (int i = 0; i < 10; i++) begin
      conv(tbl[i].v, $sformatf("vec%0d", i), res);
      chk($sformatf("vec%0d_out", i), 32'(res), 32'(tbl[i].exp));
    end

    // Second start at N+5 while busy must be dropped.
    @(negedge clk); start = 1'b1; value = 14'd1234;
    @(posedge clk);
    @(negedge clk); start = 1'b0; value = 14'd42;
    repeat (4) @(posedge clk);
    @(negedge clk); start = 1'b1; value = 14'd42;
    @(posedge clk); #1;
    chk("ign_busy", 32'(busy), 32'd1);
    @(negedge clk); start = 1'b0;
    lat = 5;
    while (lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    chk("ign_lat", 32'(lat), 32'd15);
    chk("ign_out", 32'(outs()), 32'({P1, P2, P3, P4}));
    ok = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (busy || done) ok = 1'b0;
    end
    chk("ign_noqueue", 32'(ok), 32'd1);
    $display("ignore-while-busy latency=%0d noqueue=%0d", lat, ok);

    // Reset in the middle of SHIFT aborts and restores reset patterns.
    conv(14'd9999, "pre_rst", res);
    @(negedge clk); start = 1'b1; value = 14'd1234;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_out", 32'(outs()), 32'({UZ, UZ, UZ, P0}));
    @(negedge clk); rst = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy || done) ok = 1'b0;
    end
    chk("abort_nodone", 32'(ok), 32'd1);
    $display("reset mid-shift checked nodone=%0d", ok);

    // start held high: done every 16 cycles, values 0 then 9999.
    @(negedge clk); start = 1'b1; value = 14'd0;
    @(posedge clk);
    @(negedge clk); value = 14'd9999;
    t = 0; first = 0; second = 0; r0 = '0; r1 = '0;
    while (t < 40 && second == 0) begin
      @(posedge clk); #1;
      t++;
      if (done) begin
        if (first == 0) begin first = t; r0 = outs(); end
        else begin second = t; r1 = outs(); end
      end
    end
    @(negedge clk); start = 1'b0;
    chk("held_first", 32'(first), 32'd15);
    chk("held_second", 32'(second), 32'd31);
    chk("held_out0", 32'(r0), 32'({UZ, UZ, UZ, P0}));
    chk("held_out1", 32'(r1), 32'({P9, P9, P9, P9}));
    $display("held start done at %0d and %0d", first, second);
    repeat (3) @(posedge clk);
    #1;
    chk("held_stop", 32'(busy), 32'd0);

    for (int i = 0; i < 30; i++) begin
      rv = (i % 2 == 0) ? 14'($urandom_range(0, 9999)) : 14'($urandom_range(0, 16383));
      conv(rv, $sformatf("rnd%0d", i), res);
      chk($sformatf("rnd%0d_out", i), 32'(res), 32'(model(int'(rv))));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
